// File: rtl/store_trace_fifo.sv
// Captures CPU stores that hit an address window into a FIFO for a debug reader, plus an MMIO LED register.
// Optional STORE_TRACE_TSTAMP_EN adds a 16-bit cycle stamp per entry on out_tstamp.
module store_trace_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] WIN_MATCH = 32'hFFFF_0000,
  parameter logic [31:0] WIN_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] LED_ADDR  = 32'hFFFF_0010
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
`ifdef STORE_TRACE_TSTAMP_EN
  output logic [15:0]              out_tstamp,
`endif
  output logic [3:0]               led
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [CW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt, cnt_nxt;
  logic          push, pop, push_ok, drop, full, led_hit, head_is_new;

`ifdef STORE_TRACE_TSTAMP_EN
  logic [15:0] mem_ts [DEPTH];
  logic [15:0] tstamp;
`endif

  // Push/pop decisions and the pointer state after this edge
  always_comb begin
    push        = memwrite & ((dataadr & WIN_MASK) == WIN_MATCH);
    led_hit     = memwrite & (dataadr == LED_ADDR);
    full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop         = out_valid & out_ready;
    push_ok     = push & (~full | pop);
    drop        = push & full & ~pop;
    rd_nxt      = rd_ptr + CW'(pop);
    wr_nxt      = wr_ptr + CW'(push_ok);
    cnt_nxt     = wr_nxt - rd_nxt;
    // New head is the entry being written this cycle (FIFO was empty or drains to it)
    head_is_new = (rd_nxt == wr_ptr);
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_addr[wr_ptr[AW-1:0]] <= dataadr;
      mem_data[wr_ptr[AW-1:0]] <= writedata;
`ifdef STORE_TRACE_TSTAMP_EN
      mem_ts[wr_ptr[AW-1:0]]   <= tstamp;
`endif
    end
  end

  // Pointers, registered head and status
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      led       <= '0;
`ifdef STORE_TRACE_TSTAMP_EN
      out_tstamp <= '0;
      tstamp     <= '0;
`endif
    end else begin
      rd_ptr    <= rd_nxt;
      wr_ptr    <= wr_nxt;
      count     <= cnt_nxt;
      out_valid <= (cnt_nxt != '0);
      if (cnt_nxt != '0) begin
        out_addr <= head_is_new ? dataadr   : mem_addr[rd_nxt[AW-1:0]];
        out_data <= head_is_new ? writedata : mem_data[rd_nxt[AW-1:0]];
`ifdef STORE_TRACE_TSTAMP_EN
        out_tstamp <= head_is_new ? tstamp : mem_ts[rd_nxt[AW-1:0]];
`endif
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (led_hit) led <= writedata[3:0];
`ifdef STORE_TRACE_TSTAMP_EN
      tstamp <= tstamp + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_store_trace_fifo.sv
// Directed self-checking bench for store_trace_fifo (DEPTH=8).
module tb_store_trace_fifo;

  logic        clk = 1'b0;
  logic        reset, memwrite, out_ready;
  logic [31:0] dataadr, writedata;
  logic        out_valid, overflow;
  logic [31:0] out_addr, out_data;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;
  logic [3:0]  led;
`ifdef STORE_TRACE_TSTAMP_EN
  logic [15:0] out_tstamp;
`endif

  int n_cmp = 0;
  int n_err = 0;

  store_trace_fifo dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt),
`ifdef STORE_TRACE_TSTAMP_EN
    .out_tstamp(out_tstamp),
`endif
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0; dataadr = '0; writedata = '0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] exp_q [9];

  initial begin
    reset = 1'b1; memwrite = 1'b0; out_ready = 1'b0; dataadr = '0; writedata = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_addr", out_addr, 32'd0);

    // single capture, held stable without ready
    store(32'hFFFF_0004, 32'hDEAD_BEEF);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_addr", out_addr, 32'hFFFF_0004);
    check("t1_count", 32'(count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold", out_data, 32'hDEAD_BEEF);
    end
    pop_one();
    check("t1_empty", 32'(out_valid), 32'd0);
    check("t1_keep", out_data, 32'hDEAD_BEEF);

    // empty fifo ignores ready
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("empty_rdy", 32'(count), 32'd0);

    // outside window
    store(32'h0000_0020, 32'h0000_1234);
    check("t2_valid", 32'(out_valid), 32'd0);
    check("t2_count", 32'(count), 32'd0);
    check("t2_led", 32'(led), 32'd0);

    // LED register inside window
    store(32'hFFFF_0010, 32'h0000_000A);
    check("t3_led", 32'(led), 32'hA);
    check("t3_count", 32'(count), 32'd1);
    check("t3_addr", out_addr, 32'hFFFF_0010);
    // push+pop mid-fill keeps count
    out_ready = 1'b1;
    store(32'hFFFF_0008, 32'h77);
    out_ready = 1'b0;
    check("pp_count", 32'(count), 32'd1);
    check("pp_data", out_data, 32'h77);
    pop_one();

    // overflow: 10 stores into 8 entries
    for (int i = 1; i <= 10; i++) store(32'hFFFF_0000 + 32'(4 * i), 32'(i));
    check("t4_count", 32'(count), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_drop", 32'(drop_cnt), 32'd2);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_data", out_data, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("t4_drained", 32'(out_valid), 32'd0);

    // full with simultaneous pop and push
    for (int i = 0; i < 8; i++) store(32'hFFFF_0100, 32'h11 + 32'(i));
    out_ready = 1'b1;
    store(32'hFFFF_0104, 32'h55);
    check("t5_count", 32'(count), 32'd8);
    check("t5_ovf", 32'(overflow), 32'd1);
    check("t5_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 7; i++) exp_q[i] = 32'h12 + 32'(i);
    exp_q[7] = 32'h55;
    for (int i = 0; i < 8; i++) begin
      check("t5_data", out_data, exp_q[i]);
      tick();
    end
    out_ready = 1'b0;
    check("t5_drained", 32'(out_valid), 32'd0);

    // drop counter saturates
    for (int i = 0; i < 8; i++) store(32'hFFFF_0200, 32'(i));
    for (int i = 0; i < 260; i++) store(32'hFFFF_0204, 32'hEE);
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_head", out_data, 32'd0);

    // reset mid-stream overrides a same-cycle store
    reset = 1'b1; tick(); reset = 1'b0;
    store(32'hFFFF_0010, 32'h5);
    for (int i = 0; i < 4; i++) store(32'hFFFF_0300, 32'(i));
    check("t6_pre", 32'(count), 32'd5);
    reset = 1'b1;
    store(32'hFFFF_0010, 32'hF);
    reset = 1'b0;
    check("t6_count", 32'(count), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_led", 32'(led), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_drop", 32'(drop_cnt), 32'd0);
`ifdef STORE_TRACE_TSTAMP_EN
    store(32'hFFFF_0400, 32'h1);
    check("t6_tstamp", 32'(out_tstamp), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
